// File: rtl/mem_io_bridge_if.sv
// Memory-stage bus between the core and mem_io_bridge: load/store request,
// combinational load data, LED/error outputs and the TX byte stream.
interface mem_io_bridge_if #(
    parameter int LED_W = 16
);
    logic             memwrite;
    logic [31:0]      addr;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [LED_W-1:0] led;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             err;

    modport master (
        output memwrite, addr, writedata, tx_ready,
        input  readdata, led, tx_data, tx_valid, err
    );

    modport slave (
        input  memwrite, addr, writedata, tx_ready,
        output readdata, led, tx_data, tx_valid, err
    );
endinterface

// File: rtl/mem_io_bridge.sv
// M-stage memory slave: word-addressed data RAM plus an I/O page holding the
// LED register, a free-running timer and a TX byte FIFO with sticky status.
module mem_io_bridge #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int LED_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_io_bridge_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0] LED_ADDR   = 32'hFFFF_FF00;
    localparam logic [31:0] TIMER_ADDR = 32'hFFFF_FF04;
    localparam logic [31:0] TX_ADDR    = 32'hFFFF_FF08;
    localparam logic [31:0] CLR_ADDR   = 32'hFFFF_FF0C;

    logic [31:0]      ram [RAM_WORDS];
    logic [7:0]       fifo [FIFO_DEPTH];
    logic [LED_W-1:0] led_q;
    logic [31:0]      timer_q;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             overflow, err_q;

    logic          ram_sel, led_sel, timer_sel, tx_sel, clr_sel, mapped;
    logic [AW-1:0] ram_idx;
    logic          fifo_full, fifo_empty, pop, push_req, push_ok, ovf_set, bad_wr, clr_wr;
    logic [31:0]   status, led_ext;

    assign ram_sel   = (bus.addr[1:0] == 2'b00) && (bus.addr[31:AW+2] == '0);
    assign ram_idx   = bus.addr[AW+1:2];
    assign led_sel   = (bus.addr == LED_ADDR);
    assign timer_sel = (bus.addr == TIMER_ADDR);
    assign tx_sel    = (bus.addr == TX_ADDR);
    assign clr_sel   = (bus.addr == CLR_ADDR);
    assign mapped    = ram_sel || led_sel || timer_sel || tx_sel || clr_sel;

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = !fifo_empty && bus.tx_ready;
    assign push_req   = bus.memwrite && tx_sel;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;
    assign bad_wr     = bus.memwrite && !mapped;
    assign clr_wr     = bus.memwrite && clr_sel;

    always_comb begin
        status      = '0;
        status[31]  = overflow;
        status[30]  = err_q;
        status[9]   = fifo_empty;
        status[8]   = fifo_full;
        status[7:0] = 8'(count);
        led_ext             = '0;
        led_ext[LED_W-1:0]  = led_q;
    end

    always_comb begin
        bus.readdata = '0;
        if (ram_sel)        bus.readdata = ram[ram_idx];
        else if (led_sel)   bus.readdata = led_ext;
        else if (timer_sel) bus.readdata = timer_q;
        else if (tx_sel)    bus.readdata = status;
    end

    // Storage arrays carry no reset; only their pointers and count do.
    always_ff @(posedge clk) begin
        if (bus.memwrite && ram_sel) ram[ram_idx] <= bus.writedata;
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo[wr_ptr] <= bus.writedata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q    <= '0;
            timer_q  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (bus.memwrite && led_sel) led_q <= bus.writedata[LED_W-1:0];
            timer_q <= (bus.memwrite && timer_sel) ? bus.writedata : timer_q + 32'd1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set beats clear when both land on the same edge.
            overflow <= ovf_set || (overflow && !clr_wr);
            err_q    <= bad_wr  || (err_q && !clr_wr);
        end
    end

    assign bus.led      = led_q;
    assign bus.tx_data  = fifo[rd_ptr];
    assign bus.tx_valid = !fifo_empty;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed and randomized checks of mem_io_bridge against a queue/array model.
module tb_mem_io_bridge;
    localparam int RAM_WORDS  = 64;
    localparam int FIFO_DEPTH = 8;
    localparam int LED_W      = 16;

    localparam logic [31:0] LED_A = 32'hFFFF_FF00;
    localparam logic [31:0] TMR_A = 32'hFFFF_FF04;
    localparam logic [31:0] TX_A  = 32'hFFFF_FF08;
    localparam logic [31:0] CLR_A = 32'hFFFF_FF0C;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mem_io_bridge_if #(.LED_W(LED_W)) bus ();

    mem_io_bridge #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .LED_W     (LED_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] ram_m [RAM_WORDS];
    bit          ram_v [RAM_WORDS];
    logic [7:0]  q [$];
    bit          ovf_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite  = 1'b1;
        bus.addr      = a;
        bus.writedata = d;
        tick();
        bus.memwrite  = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.memwrite = 1'b0;
        bus.addr     = a;
        #1;
        chk(tag, bus.readdata, exp);
    endtask

    function automatic logic [31:0] status_m(input bit ovf, input bit er, input int cnt);
        return (ovf ? 32'h8000_0000 : 32'h0) | (er ? 32'h4000_0000 : 32'h0) |
               (cnt == 0 ? 32'h200 : 32'h0) | (cnt == FIFO_DEPTH ? 32'h100 : 32'h0) | 32'(cnt);
    endfunction

    initial begin
        logic [7:0] exp_bytes [8];
        reset        = 1'b1;
        bus.memwrite = 1'b0;
        bus.addr     = '0;
        bus.writedata = '0;
        bus.tx_ready = 1'b0;
        #1;
        chk("reset_led", 32'(bus.led), 32'h0);
        chk("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("reset_err", 32'(bus.err), 32'h0);
        chk_rd("reset_status", TX_A, 32'h0000_0200);
        #12;
        reset = 1'b0;
        tick();

        // RAM write/read-back and LED
        wr(32'h10, 32'hDEAD_BEEF);
        wr(32'h14, 32'h1234_5678);
        chk_rd("ram_0x10", 32'h10, 32'hDEAD_BEEF);
        chk_rd("ram_0x14", 32'h14, 32'h1234_5678);
        chk("led_still_0", 32'(bus.led), 32'h0);
        wr(LED_A, 32'h0001_ABCD);
        chk("led_write", 32'(bus.led), 32'h0000_ABCD);
        chk_rd("led_read", LED_A, 32'h0000_ABCD);

        // Timer: load takes effect at the write edge, then counts each edge
        wr(TMR_A, 32'd5);
        chk_rd("timer_loaded", TMR_A, 32'd5);
        repeat (3) tick();
        chk_rd("timer_t3", TMR_A, 32'd8);
        wr(TMR_A, 32'hFFFF_FFFF);
        repeat (2) tick();
        chk_rd("timer_wrap", TMR_A, 32'd1);

        // Fill past full with the consumer stalled, then drain
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) wr(TX_A, 32'(i));
        chk_rd("status_overflow_full", TX_A, 32'h8000_0108);
        chk("err_after_overflow", 32'(bus.err), 32'h0);
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("drain_valid", 32'(bus.tx_valid), 32'h1);
            chk("drain_data", 32'(bus.tx_data), 32'(i));
            tick();
        end
        chk("drained_valid", 32'(bus.tx_valid), 32'h0);
        chk_rd("status_drained", TX_A, 32'h8000_0200);

        // Push into a full FIFO while it pops
        wr(CLR_A, 32'h0);
        bus.tx_ready = 1'b0;
        chk_rd("status_cleared", TX_A, 32'h0000_0200);
        for (int i = 0; i < 8; i++) wr(TX_A, 32'h11 + 32'(i));
        chk_rd("status_full", TX_A, 32'h0000_0108);
        bus.tx_ready = 1'b1;
        wr(TX_A, 32'h55);
        chk_rd("status_push_pop_full", TX_A, 32'h0000_0108);
        for (int i = 0; i < 7; i++) exp_bytes[i] = 8'h12 + 8'(i);
        exp_bytes[7] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            chk("order_data", 32'(bus.tx_data), 32'(exp_bytes[i]));
            tick();
        end
        chk("order_empty", 32'(bus.tx_valid), 32'h0);

        // Bad accesses and sticky clear
        bus.tx_ready = 1'b0;
        wr(32'h4, 32'hCAFE_F00D);
        chk_rd("unmapped_read", 32'h4000_0000, 32'h0);
        chk_rd("unaligned_read", 32'h6, 32'h0);
        chk("err_after_reads", 32'(bus.err), 32'h0);
        wr(32'h6, 32'h1111_1111);
        chk("err_unaligned_wr", 32'(bus.err), 32'h1);
        chk_rd("ram_untouched", 32'h4, 32'hCAFE_F00D);
        wr(32'h4000_0000, 32'h2222_2222);
        chk("err_unmapped_wr", 32'(bus.err), 32'h1);
        chk_rd("status_err", TX_A, 32'h4000_0200);
        chk_rd("clr_read", CLR_A, 32'h0);
        wr(CLR_A, 32'h0);
        chk("err_cleared", 32'(bus.err), 32'h0);
        chk_rd("status_after_clr", TX_A, 32'h0000_0200);

        // Asynchronous reset in the middle of a drain
        wr(TX_A, 32'hAA);
        wr(TX_A, 32'hBB);
        wr(TX_A, 32'hCC);
        bus.tx_ready = 1'b1;
        tick();
        chk("pre_reset_head", 32'(bus.tx_data), 32'hBB);
        reset = 1'b1;
        #1;
        chk("reset_mid_valid", 32'(bus.tx_valid), 32'h0);
        chk_rd("reset_mid_status", TX_A, 32'h0000_0200);
        chk("reset_mid_led", 32'(bus.led), 32'h0);
        chk_rd("reset_mid_timer", TMR_A, 32'h0);
        bus.tx_ready = 1'b0;
        #1;
        reset = 1'b0;
        tick();

        // Randomized traffic against the model
        ovf_m = 1'b0;
        for (int i = 0; i < RAM_WORDS; i++) ram_v[i] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            int          op;
            int          idx;
            logic [31:0] d;
            bit          pop_m, full_m;
            op  = $urandom_range(0, 5);
            idx = $urandom_range(0, RAM_WORDS - 1);
            d   = $urandom;
            bus.tx_ready  = ($urandom_range(0, 2) == 0);
            bus.memwrite  = 1'b0;
            bus.writedata = d;
            bus.addr      = TX_A;
            case (op)
                0: begin bus.memwrite = 1'b1; bus.addr = 32'(idx) * 4; end
                1: bus.addr = 32'(idx) * 4;
                2, 5: begin bus.memwrite = 1'b1; bus.addr = TX_A; end
                4: if ($urandom_range(0, 3) == 0) begin bus.memwrite = 1'b1; bus.addr = CLR_A; end
                default: bus.addr = TX_A;
            endcase
            #1;
            chk("rnd_valid", 32'(bus.tx_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("rnd_data", 32'(bus.tx_data), 32'(q[0]));
            if (op == 1 && ram_v[idx]) chk("rnd_ram", bus.readdata, ram_m[idx]);
            if (op == 3) chk("rnd_status", bus.readdata, status_m(ovf_m, 1'b0, q.size()));
            pop_m  = (q.size() != 0) && bus.tx_ready;
            full_m = (q.size() == FIFO_DEPTH);
            tick();
            if (pop_m) void'(q.pop_front());
            if (op == 0) begin ram_m[idx] = d; ram_v[idx] = 1'b1; end
            if (op == 2 || op == 5) begin
                if (!full_m || pop_m) q.push_back(d[7:0]);
                else ovf_m = 1'b1;
            end
            if (op == 4 && bus.memwrite) ovf_m = 1'b0;
            bus.memwrite = 1'b0;
        end
        chk("rnd_err_final", 32'(bus.err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
Memory-stage slave for the pipelined core. It consumes the core's M-stage memory request (memwrite, address, write data) and returns read data in the same cycle. The address space is decoded into a word-addressed data RAM and a small memory-mapped I/O page. The I/O page holds an LED register, a free-running timer, and an 8-bit transmit FIFO that drains to an external consumer over a valid/ready handshake.

Parameters:
RAM_WORDS, 64, data RAM depth in 32-bit words; power of two, 16..4096
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..128
LED_W, 16, LED register width; 1..32

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
memwrite  in  1  write strobe from M stage
addr  in  32  byte address (core ALU result)
writedata  in  32  store data
readdata  out  32  load data; combinational from addr
led  out  LED_W  LED register contents
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  consumer accepts head when tx_valid && tx_ready at a rising edge
err  out  1  sticky error flag; equals status bit30

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high. All state updates on the rising edge of clk.
- Address map (word-aligned, so addr[1:0] must be 00):
  - RAM: addr < 4*RAM_WORDS. Index is addr[log2(RAM_WORDS)+1:2].
  - 0xFFFFFF00 LED: RW. Writes take writedata[LED_W-1:0]. Reads are zero-extended.
  - 0xFFFFFF04 TIMER: RW. Free-running counter, +1 per cycle, wraps 0xFFFFFFFF to 0. A write loads writedata; the loaded value appears in the next cycle and the increment resumes after that. Write wins over increment.
  - 0xFFFFFF08 TX: a write pushes writedata[7:0]. A read returns the status word: bit31 overflow (sticky), bit30 err (sticky), bit9 empty, bit8 full, bits[7:0] count, all other bits 0.
  - 0xFFFFFF0C CLR: a write clears both sticky bits. Reads return 0.
- Unmapped or unaligned access: reads return 0. Writes are ignored and set err; a read-only access does not set err.
- readdata is combinational. Zero-wait: no stall output exists, so every access completes in its issue cycle.
- RAM is not reset. Reads of unwritten RAM are X and must not be checked.
- FIFO:
  - pop = tx_valid && tx_ready.
  - push is accepted if count<FIFO_DEPTH, or if full with a pop in the same cycle (net count unchanged).
  - A push while full with no pop is dropped and sets overflow.
  - Order is strictly FIFO. Pointers wrap modulo FIFO_DEPTH.
  - tx_data is X when empty. tx_valid = (count!=0), registered-state derived and glitch-free.
- Sticky bits: if a CLR write coincides with a new error event in the same cycle, the set wins.
- Reset values: led=0, timer=0, count=0, pointers=0, tx_valid=0, overflow=0, err=0. An asynchronous reset mid-drain discards FIFO contents immediately.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10 and 0x12345678 to 0x14; read back. -> readdata equals each value in the same cycle; led=0.
- Write 0x1ABCD to 0xFFFFFF00 -> led=0xABCD (LED_W=16); a read of 0xFFFFFF00 returns 0x0000ABCD.
- Write 5 to the timer at cycle t; read at t+3. -> 0x00000008. Load 0xFFFFFFFF; read 2 cycles later. -> 0x00000001.
- With tx_ready=0, push 9 bytes 0x01..0x09 (FIFO_DEPTH=8). -> status 0x80000108, byte 0x09 lost. Raise tx_ready. -> tx_data 0x01..0x08 in order, one per cycle; then tx_valid=0 and status 0x80000200.
- Full FIFO, tx_ready=1, push 0x55 in the same cycle. -> accepted; count stays 8; overflow unchanged.
- Write to 0x00000006 and to 0x40000000 -> err=1, RAM unchanged. Then write to CLR. -> err=0 and status bit31=0. Assert reset mid-drain. -> tx_valid=0 immediately, status 0x00000200.
